// File: rtl/mlp_nn_pkg.sv
// mlp_nn_pkg: shared state encoding, layer selectors and saturating arithmetic helpers.
package mlp_nn_pkg;
    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;
    localparam logic LAYER_W1 = 1'b0;
    localparam logic LAYER_W2 = 1'b1;
    typedef logic signed [63:0] wide_t;
    function automatic wide_t clamp_signed(wide_t v, int bits);
        wide_t hi, lo;
        hi = (wide_t'(1) <<< (bits - 1)) - 1;
        lo = -hi - 1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
    function automatic wide_t clamp_relu(wide_t v, int bits);
        return v < 0 ? '0 : clamp_signed(v, bits);
    endfunction
    function automatic wide_t sat_add(wide_t a, wide_t b, int bits);
        return clamp_signed(a + b, bits);
    endfunction
endpackage

// File: rtl/mlp_nn_if.sv
// mlp_nn_if: weight-write port plus input/output valid-ready handshakes.
interface mlp_nn_if #(parameter int BITS = 8, parameter int I = 2, parameter int O = 1,
                      parameter int AN = 2, parameter int AM = 2);
    logic                   weights_en;
    logic                   weights_layer_address;
    logic [AN-1:0]          weights_n_address;
    logic [AM-1:0]          weights_m_address;
    logic signed [BITS-1:0] weights_data;
    logic                   weights_dropped;
    logic                   in_valid;
    logic                   in_ready;
    logic [I*BITS-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [O*BITS-1:0]      out_score;
    logic [O-1:0]           out_data;
    modport slave (input weights_en, weights_layer_address, weights_n_address, weights_m_address,
                   weights_data, in_valid, in_data, out_ready,
                   output weights_dropped, in_ready, out_valid, out_score, out_data);
    modport master (output weights_en, weights_layer_address, weights_n_address, weights_m_address,
                    weights_data, in_valid, in_data, out_ready,
                    input weights_dropped, in_ready, out_valid, out_score, out_data);
endinterface

// File: rtl/mlp_nn_mac.sv
// mlp_mac: signed multiply with saturating accumulate; sum_o already includes the current term.
module mlp_mac import mlp_nn_pkg::*; #(
    parameter int BITS     = 8,
    parameter int ACC_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic signed [BITS-1:0]     a_i,
    input  logic signed [BITS-1:0]     b_i,
    output logic signed [ACC_BITS-1:0] sum_o
);
    logic signed [ACC_BITS-1:0] acc_q;
    logic signed [2*BITS-1:0]   prod;
    assign prod  = a_i * b_i;
    assign sum_o = ACC_BITS'(sat_add(wide_t'(acc_q), wide_t'(prod), ACC_BITS));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else if (en_i) acc_q <= clr_i ? '0 : sum_o;
    end
endmodule

// File: rtl/mlp_nn.sv
// mlp_nn: two-layer perceptron, one time-multiplexed MAC, run-time loadable weights.
module mlp_nn import mlp_nn_pkg::*; #(
    parameter int BITS_PER_WORD = 8,
    parameter int INPUT_SIZE    = 2,
    parameter int HIDDEN_SIZE   = 2,
    parameter int OUTPUT_SIZE   = 1,
    parameter int ACC_BITS      = 16,
    parameter int ADDR_N_BITS   = 2,
    parameter int ADDR_M_BITS   = 2
) (
    input logic   clk,
    input logic   reset_n,
    mlp_nn_if.slave bus
);
    localparam int B  = BITS_PER_WORD;
    localparam int AN = ADDR_N_BITS;
    localparam int AM = ADDR_M_BITS;
    state_e                 state_q;
    logic [AN-1:0]          k_q;
    logic [AM-1:0]          j_q;
    logic                   out_valid_q, dropped_q;
    // Arrays span the full address space so counters index them directly; index 0 holds the bias 1.
    logic signed [B-1:0]    x_q [2**AN];
    logic signed [B-1:0]    h_q [2**AN];
    logic signed [B-1:0]    w1_q [2**AN][2**AM];
    logic signed [B-1:0]    w2_q [2**AN][2**AM];
    logic signed [B-1:0]    score_q [2**AM];
    logic signed [B-1:0]    a, b;
    logic signed [ACC_BITS-1:0] sum;
    logic                   last_k, last_j, w_ok, w_take, mac_en;
    always_comb begin
        last_k = state_q == L1 ? k_q == AN'(INPUT_SIZE) : k_q == AN'(HIDDEN_SIZE);
        last_j = state_q == L1 ? j_q == AM'(HIDDEN_SIZE - 1) : j_q == AM'(OUTPUT_SIZE - 1);
        a      = state_q == L1 ? x_q[k_q] : h_q[k_q];
        b      = state_q == L1 ? w1_q[k_q][j_q] : w2_q[k_q][j_q];
        mac_en = state_q == L1 || state_q == L2;
        w_ok   = bus.weights_layer_address == LAYER_W1
               ? 32'(bus.weights_n_address) <= INPUT_SIZE && 32'(bus.weights_m_address) < HIDDEN_SIZE
               : 32'(bus.weights_n_address) <= HIDDEN_SIZE && 32'(bus.weights_m_address) < OUTPUT_SIZE;
        w_take = bus.weights_en && state_q == IDLE && w_ok;
    end
    mlp_mac #(.BITS(B), .ACC_BITS(ACC_BITS)) u_mac (
        .clk(clk), .reset_n(reset_n), .en_i(mac_en), .clr_i(last_k),
        .a_i(a), .b_i(b), .sum_o(sum)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
            x_q         <= '{default: '0};
            h_q         <= '{default: '0};
            w1_q        <= '{default: '0};
            w2_q        <= '{default: '0};
            score_q     <= '{default: '0};
        end else begin
            dropped_q <= bus.weights_en && !w_take;
            if (w_take && bus.weights_layer_address == LAYER_W1)
                w1_q[bus.weights_n_address][bus.weights_m_address] <= bus.weights_data;
            if (w_take && bus.weights_layer_address == LAYER_W2)
                w2_q[bus.weights_n_address][bus.weights_m_address] <= bus.weights_data;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    state_q <= L1;
                    x_q[0]  <= B'(1);
                    h_q[0]  <= B'(1);
                    for (int n = 0; n < INPUT_SIZE; n++) x_q[n+1] <= bus.in_data[n*B +: B];
                end
                L1: begin
                    k_q <= last_k ? '0 : k_q + 1'b1;
                    if (last_k) begin
                        h_q[AN'(j_q) + 1'b1] <= B'(clamp_relu(wide_t'(sum), B));
                        j_q <= last_j ? '0 : j_q + 1'b1;
                        if (last_j) state_q <= L2;
                    end
                end
                L2: begin
                    k_q <= last_k ? '0 : k_q + 1'b1;
                    if (last_k) begin
                        score_q[j_q] <= B'(clamp_signed(wide_t'(sum), B));
                        j_q <= last_j ? '0 : j_q + 1'b1;
                        if (last_j) state_q <= DONE;
                    end
                end
                DONE: begin
                    out_valid_q <= out_valid_q ? !bus.out_ready : 1'b1;
                    state_q     <= out_valid_q && bus.out_ready ? IDLE : DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready        = state_q == IDLE;
    assign bus.out_valid       = out_valid_q;
    assign bus.weights_dropped = dropped_q;
    always_comb begin
        bus.out_score = '0;
        bus.out_data  = '0;
        for (int n = 0; n < OUTPUT_SIZE; n++) begin
            bus.out_score[n*B +: B] = score_q[n];
            bus.out_data[n]         = score_q[n] > 0;
        end
    end
endmodule

// File: tb/tb_mlp_nn.sv
// tb_mlp_nn: directed vectors with a queue scoreboard checked by an independent output monitor.
module tb_mlp_nn;
    localparam int BITS = 8, I = 2, H = 2, O = 1, AN = 2, AM = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    mlp_nn_if #(.BITS(BITS), .I(I), .O(O), .AN(AN), .AM(AM)) bus ();
    mlp_nn #(.BITS_PER_WORD(BITS), .INPUT_SIZE(I), .HIDDEN_SIZE(H), .OUTPUT_SIZE(O),
             .ACC_BITS(16), .ADDR_N_BITS(AN), .ADDR_M_BITS(AM))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    typedef struct packed {logic signed [BITS-1:0] s; logic d;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int checks = 0, errors = 0, pushed = 0, popped = 0;
    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                mon_e = q.pop_front();
                chk("out_score", $signed(bus.out_score), mon_e.s);
                chk("out_data", bus.out_data, mon_e.d);
                popped++;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(int es);
        exp_t e;
        e.s = BITS'(es);
        e.d = es > 0;
        q.push_back(e);
        pushed++;
    endtask
    task automatic wr(logic l, int n, int m, int d, logic drop);
        bus.weights_en = 1'b1;
        bus.weights_layer_address = l;
        bus.weights_n_address = AN'(n);
        bus.weights_m_address = AM'(m);
        bus.weights_data = BITS'(d);
        tick();
        bus.weights_en = 1'b0;
        chk("weights_dropped", bus.weights_dropped, drop);
    endtask
    task automatic xor_w();
        wr(0, 0, 0, 0, 0); wr(0, 0, 1, -1, 0);
        wr(0, 1, 0, 1, 0); wr(0, 1, 1, 1, 0);
        wr(0, 2, 0, 1, 0); wr(0, 2, 1, 1, 0);
        wr(1, 0, 0, 0, 0); wr(1, 1, 0, 1, 0); wr(1, 2, 0, -2, 0);
    endtask
    task automatic wait_idle();
        int c = 0;
        while (!bus.in_ready && c < 100) begin
            tick();
            c++;
        end
        if (!bus.in_ready) chk("idle_timeout", 0, 1);
    endtask
    // ab: cycle at which to assert reset (0 = never); wrc: cycle of an illegal weight write (0 = none)
    task automatic infer(int x0, int x1, int es, int ab, int wrc);
        wait_idle();
        if (ab == 0) push(es);
        bus.in_data = {BITS'(x1), BITS'(x0)};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("in_ready_busy", bus.in_ready, 0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == wrc) begin
                bus.weights_en = 1'b1;
                bus.weights_layer_address = 1'b1;
                bus.weights_n_address = '0;
                bus.weights_m_address = '0;
                bus.weights_data = BITS'(100);
            end
            if (wrc > 0 && c == wrc + 1) begin
                bus.weights_en = 1'b0;
                chk("dropped_busy", bus.weights_dropped, 1);
            end
            if (c == ab) begin
                reset_n = 1'b0;
                #1;
                chk("abort_out_valid", bus.out_valid, 0);
                chk("abort_in_ready", bus.in_ready, 1);
                tick();
                reset_n = 1'b1;
                return;
            end
            if (bus.out_valid) begin
                chk("latency", c, 10);
                return;
            end
        end
        chk("valid_timeout", 0, 1);
    endtask
    int bx0[4] = '{0, 0, 1, 1};
    int bx1[4] = '{0, 1, 0, 1};
    int bex[4] = '{0, 1, 1, 0};
    initial begin
        bus.weights_en = 1'b0;
        bus.weights_layer_address = 1'b0;
        bus.weights_n_address = '0;
        bus.weights_m_address = '0;
        bus.weights_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_score", $signed(bus.out_score), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_dropped", bus.weights_dropped, 0);
        tick();
        xor_w();
        for (int n = 0; n < 4; n++) infer(bx0[n], bx1[n], bex[n], 0, 0);
        wait_idle();
        wr(0, 3, 0, 5, 1);
        wr(1, 0, 1, 5, 1);
        infer(0, 1, 1, 0, 1);
        wait_idle();
        for (int n = 0; n <= I; n++) for (int m = 0; m < H; m++) wr(0, n, m, 127, 0);
        wr(1, 0, 0, 0, 0); wr(1, 1, 0, 127, 0); wr(1, 2, 0, 127, 0);
        infer(127, 127, 127, 0, 0);
        wait_idle();
        wr(1, 1, 0, -128, 0); wr(1, 2, 0, -128, 0);
        infer(127, 127, -128, 0, 0);
        wait_idle();
        bus.out_ready = 1'b0;
        infer(1, 1, -128, 0, 0);
        bus.in_data = {BITS'(5), BITS'(5)};
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_score", $signed(bus.out_score), -128);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);
        infer(1, 1, 0, 8, 0);
        infer(1, 1, 0, 0, 0);
        infer(127, 127, 0, 0, 0);
        wait_idle();
        xor_w();
        for (int n = 0; n < 4; n++) begin
            int c = 0;
            push(bex[n]);
            bus.in_data = {BITS'(bx1[n]), BITS'(bx0[n])};
            bus.in_valid = 1'b1;
            while (!bus.in_ready && c < 50) begin
                tick();
                c++;
            end
            if (!bus.in_ready) chk("b2b_timeout", 0, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        chk("result_count", popped, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
